// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared address map, FSM states and reset values for the SNN inference sequencer
package snn_ctrl_pkg;

  // Register byte addresses (paddr[1:0] is ignored on decode)
  localparam logic [7:0] ADDR_CTRL        = 8'h00;
  localparam logic [7:0] ADDR_STATUS      = 8'h04;
  localparam logic [7:0] ADDR_LEAK        = 8'h08;
  localparam logic [7:0] ADDR_STEPS       = 8'h0C;
  localparam logic [7:0] ADDR_RESULT      = 8'h10;
  localparam logic [7:0] ADDR_PIXEL_BASE  = 8'h40;
  localparam logic [7:0] ADDR_SCOUNT_BASE = 8'h80;

  // Timestep count after reset
  localparam logic [7:0] STEPS_RESET = 8'd8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    ARGMAX,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/snn_spike_accum.sv
// rtl/snn_spike_accum.sv - per-digit saturating spike counters and sequential argmax scan
module snn_spike_accum
  import snn_ctrl_pkg::*;
#(
  parameter int OUTPUT_SIZE = 16,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         enable,
  input  logic [OUTPUT_SIZE-1:0]       spikes,
  input  logic                         scan_en,
  output logic [OUTPUT_SIZE*CNT_W-1:0] counts,
  output logic                         scan_last,
  output logic [3:0]                   winner,
  output logic [CNT_W-1:0]             win_count
);

  localparam int IDX_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

  logic [CNT_W-1:0] cnt [OUTPUT_SIZE];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  // Count one per set spike bit on enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        if (spikes[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Walk one counter per cycle; strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (clear) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (scan_en) begin
      if (cnt[idx] > best_cnt) begin
        best_cnt <= cnt[idx];
        best_idx <= idx;
      end
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_counts
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign scan_last = (idx == LAST_IDX);
  assign winner    = 4'(best_idx);
  assign win_count = best_cnt;

endmodule

// File: rtl/snn_infer_ctrl.sv
// rtl/snn_infer_ctrl.sv - APB inference sequencer (clear, N timesteps, argmax); irq gated by SNN_CTRL_IRQ_EN
module snn_infer_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_W       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [7:0]                        paddr,
  input  logic [31:0]                       pwdata,
  output logic [31:0]                       prdata,
  output logic                              pready,
  output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_input,
  output logic [7:0]                        leak_factor,
  output logic                              net_clear,
  output logic                              net_step,
  input  logic [OUTPUT_SIZE-1:0]            digit_spikes,
  output logic                              irq
);

  localparam int PIX_WORDS = INPUT_SIZE / 4;
  localparam logic [4:0] PIX_WORDS_L = 5'(PIX_WORDS);
  localparam logic [4:0] OUT_L       = 5'(OUTPUT_SIZE);

  ctrl_state_e state, state_next;
  logic [7:0]  leak, steps, steps_left;
  logic [31:0] pix_word [PIX_WORDS];
  logic [CNT_W-1:0] scount [OUTPUT_SIZE];
  logic [OUTPUT_SIZE*CNT_W-1:0] counts;
  logic        done_flag, step_d, busy, wr, start_req;
  logic        acc_clear, scan_en, scan_last, set_done, irq_en_rd;
  logic [3:0]  winner, result_winner;
  logic [CNT_W-1:0] win_count, result_cnt;
  logic        hit_ctrl, hit_status, hit_leak, hit_steps, hit_result, hit_pix, hit_sc;
  logic        unused;

  assign pready    = 1'b1;
  assign wr        = psel & penable & pwrite;
  assign busy      = (state != IDLE);
  assign unused    = ^paddr[1:0];

  assign hit_ctrl   = (paddr[7:2] == ADDR_CTRL[7:2]);
  assign hit_status = (paddr[7:2] == ADDR_STATUS[7:2]);
  assign hit_leak   = (paddr[7:2] == ADDR_LEAK[7:2]);
  assign hit_steps  = (paddr[7:2] == ADDR_STEPS[7:2]);
  assign hit_result = (paddr[7:2] == ADDR_RESULT[7:2]);
  assign hit_pix    = (paddr[7:6] == ADDR_PIXEL_BASE[7:6]) && ({1'b0, paddr[5:2]} < PIX_WORDS_L);
  assign hit_sc     = (paddr[7:6] == ADDR_SCOUNT_BASE[7:6]) && ({1'b0, paddr[5:2]} < OUT_L);
  assign start_req  = wr && hit_ctrl && pwdata[0];

  // State register, timestep countdown and the net_step delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      steps_left <= '0;
      step_d     <= 1'b0;
    end else begin
      state  <= state_next;
      step_d <= net_step;
      if (state == IDLE && start_req) steps_left <= steps;
      else if (state == RUN)          steps_left <= steps_left - 1'b1;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_next = state;
    net_clear  = 1'b0;
    net_step   = 1'b0;
    acc_clear  = 1'b0;
    scan_en    = 1'b0;
    set_done   = 1'b0;
    case (state)
      IDLE: if (start_req) begin
        state_next = CLEAR;
        acc_clear  = 1'b1;
      end
      CLEAR: begin
        net_clear  = 1'b1;
        state_next = (steps_left == 8'd0) ? DRAIN : RUN;
      end
      RUN: begin
        net_step = 1'b1;
        if (steps_left == 8'd1) state_next = DRAIN;
      end
      DRAIN:  state_next = ARGMAX;
      ARGMAX: begin
        scan_en = 1'b1;
        if (scan_last) state_next = DONE;
      end
      DONE: begin
        set_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Network configuration registers; frozen while an inference is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leak  <= '0;
      steps <= STEPS_RESET;
      for (int i = 0; i < PIX_WORDS; i++) pix_word[i] <= '0;
    end else if (wr && !busy) begin
      if (hit_leak)  leak  <= pwdata[7:0];
      if (hit_steps) steps <= pwdata[7:0];
      if (hit_pix)   pix_word[paddr[5:2]] <= pwdata;
    end
  end

  // DONE flag and RESULT capture; a start clears DONE ahead of any W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_flag     <= 1'b0;
      result_winner <= '0;
      result_cnt    <= '0;
    end else begin
      if (set_done)                           done_flag <= 1'b1;
      else if (acc_clear)                     done_flag <= 1'b0;
      else if (wr && hit_status && pwdata[1]) done_flag <= 1'b0;
      if (set_done) begin
        result_winner <= winner;
        result_cnt    <= win_count;
      end
    end
  end

`ifdef SNN_CTRL_IRQ_EN
  logic irq_en, irq_q;

  // Interrupt enable and registered level interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && hit_ctrl) irq_en <= pwdata[1];
      irq_q <= done_flag & irq_en;
    end
  end
  assign irq       = irq_q;
  assign irq_en_rd = irq_en;
`else
  assign irq       = 1'b0;
  assign irq_en_rd = 1'b0;
`endif

  snn_spike_accum #(
    .OUTPUT_SIZE(OUTPUT_SIZE),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .enable   (step_d),
    .spikes   (digit_spikes),
    .scan_en  (scan_en),
    .counts   (counts),
    .scan_last(scan_last),
    .winner   (winner),
    .win_count(win_count)
  );

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_scount
    assign scount[g] = counts[g*CNT_W +: CNT_W];
  end

  for (genvar g = 0; g < PIX_WORDS; g++) begin : g_pix
    assign pixel_input[32*g +: 32] = pix_word[g];
  end

  assign leak_factor = leak;

  // Combinational read mux, zero unless a read is selected
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      if (hit_ctrl)        prdata = {30'b0, irq_en_rd, 1'b0};
      else if (hit_status) prdata = {30'b0, done_flag, busy};
      else if (hit_leak)   prdata = {24'b0, leak};
      else if (hit_steps)  prdata = {24'b0, steps};
      else if (hit_result) prdata = {16'b0, 8'(result_cnt), 4'b0, result_winner};
      else if (hit_pix)    prdata = pix_word[paddr[5:2]];
      else if (hit_sc)     prdata = 32'(scount[paddr[5:2]]);
    end
  end

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// tb/tb_snn_infer_ctrl.sv - scoreboard bench for snn_infer_ctrl
module tb_snn_infer_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready;
  logic [511:0] pixel_input;
  logic [7:0]   leak_factor;
  logic         net_clear, net_step;
  logic [15:0]  digit_spikes;
  logic         irq;

  typedef struct { string name; logic [31:0] val; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;
  exp_t exp_q[$];
  chk_t chk_q[$];
  exp_t e;
  chk_t c;

  int total = 0;
  int bad = 0;
  int step_total = 0;
  int clear_total = 0;
  int s0, c0, n;

  localparam int BOUND = 400;

  snn_infer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pixel_input (pixel_input),
    .leak_factor (leak_factor),
    .net_clear   (net_clear),
    .net_step    (net_step),
    .digit_spikes(digit_spikes),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Monitor: pulse counters, APB read scoreboard and queued direct checks
  always @(negedge clk) begin
    if (net_step)  step_total++;
    if (net_clear) clear_total++;
    if (psel && penable && !pwrite) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got 0x%08h want no read", prdata);
      end else begin
        e = exp_q.pop_front();
        if (prdata !== e.val) begin
          bad++;
          $display("FAIL %s: got 0x%08h want 0x%08h", e.name, prdata, e.val);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", c.name, c.act, c.exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back('{name, exp});
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Hold a STATUS read in setup phase and count edges until DONE shows
  task automatic wait_done(output int cycles);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 8'h04;
    cycles = 0;
    while (cycles < BOUND) begin
      @(posedge clk); #1;
      cycles++;
      if (prdata[1]) break;
    end
    psel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; digit_spikes = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset read-back
    apb_read(8'h00, 32'h0, "rst_ctrl");
    apb_read(8'h04, 32'h0, "rst_status");
    apb_read(8'h08, 32'h0, "rst_leak");
    apb_read(8'h0C, 32'h8, "rst_steps");
    apb_read(8'h10, 32'h0, "rst_result");
    apb_read(8'h40, 32'h0, "rst_pix0");
    apb_read(8'h80, 32'h0, "rst_scount0");
    apb_read(8'h20, 32'h0, "rst_unmapped");
    check("rst_net_step", 32'(net_step), 0);
    check("rst_net_clear", 32'(net_clear), 0);
    check("rst_irq", 32'(irq), 0);
    check("pready", 32'(pready), 1);

    // Basic inference: digit 3 spikes, STEPS=4
    for (int k = 0; k < 16; k++) apb_write(8'(64 + 4 * k), 32'h80808080);
    apb_write(8'h08, 32'h10);
    apb_write(8'h0C, 32'd4);
    digit_spikes = 16'h0008;
    s0 = step_total; c0 = clear_total;
    apb_write(8'h00, 32'h1);
    wait_done(n);
    check("t2_latency", 32'(n), 23);
    check("t2_steps", 32'(step_total - s0), 4);
    check("t2_clears", 32'(clear_total - c0), 1);
    apb_read(8'h8C, 32'd4, "t2_scount3");
    apb_read(8'h80, 32'd0, "t2_scount0");
    apb_read(8'h10, 32'h0403, "t2_result");
    apb_read(8'h04, 32'h2, "t2_status");
    apb_read(8'h08, 32'h10, "t2_leak");
    apb_read(8'h54, 32'h80808080, "t2_pix5");
    check("t2_pixel_out", 32'(pixel_input[7:0]), 32'h80);
    check("t2_leak_out", 32'(leak_factor), 32'h10);

    // DONE W1C, then tie between digits 2 and 5
    apb_write(8'h04, 32'h2);
    apb_read(8'h04, 32'h0, "t3_w1c");
    apb_write(8'h0C, 32'd5);
    digit_spikes = 16'h0024;
    apb_write(8'h00, 32'h1);
    wait_done(n);
    check("t3_latency", 32'(n), 24);
    apb_read(8'h10, 32'h0502, "t3_result_tie");
    apb_read(8'h94, 32'd5, "t3_scount5");
    apb_read(8'h88, 32'd5, "t3_scount2");

    // 255 steps on digit 0, twice
    apb_write(8'h0C, 32'd255);
    digit_spikes = 16'h0001;
    for (int r = 0; r < 2; r++) begin
      s0 = step_total;
      apb_write(8'h00, 32'h1);
      wait_done(n);
      check("t4_latency", 32'(n), 274);
      check("t4_steps", 32'(step_total - s0), 255);
      apb_read(8'h80, 32'd255, "t4_scount0");
      apb_read(8'h10, 32'hFF00, "t4_result");
    end

    // STEPS=0
    apb_write(8'h0C, 32'd0);
    digit_spikes = 16'hFFFF;
    s0 = step_total; c0 = clear_total;
    apb_write(8'h00, 32'h1);
    wait_done(n);
    check("t5_latency", 32'(n), 19);
    check("t5_steps", 32'(step_total - s0), 0);
    check("t5_clears", 32'(clear_total - c0), 1);
    apb_read(8'hBC, 32'd0, "t5_scount15");
    apb_read(8'h10, 32'h0, "t5_result");

    // Busy protection
    apb_write(8'h0C, 32'd20);
    digit_spikes = 16'h0001;
    s0 = step_total; c0 = clear_total;
    apb_write(8'h00, 32'h1);
    apb_write(8'h08, 32'h55);
    apb_write(8'h40, 32'h12345678);
    apb_write(8'h00, 32'h1);
    apb_write(8'h0C, 32'd3);
    wait_done(n);
    check("t6_latency", 32'(n), 27);
    repeat (30) @(posedge clk);
    #1;
    check("t6_steps", 32'(step_total - s0), 20);
    check("t6_clears", 32'(clear_total - c0), 1);
    apb_read(8'h08, 32'h10, "t6_leak");
    apb_read(8'h40, 32'h80808080, "t6_pix0");
    apb_read(8'h0C, 32'd20, "t6_steps_reg");
    apb_read(8'h80, 32'd20, "t6_scount0");
    apb_read(8'h10, 32'h1400, "t6_result");
    apb_read(8'h04, 32'h2, "t6_status");

    // Reset during RUN, then a clean inference
    apb_write(8'h0C, 32'd10);
    digit_spikes = 16'h0002;
    apb_write(8'h00, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t7_net_step", 32'(net_step), 0);
    check("t7_net_clear", 32'(net_clear), 0);
    check("t7_irq", 32'(irq), 0);
    check("t7_pixel_out", 32'(pixel_input[7:0]), 0);
    check("t7_leak_out", 32'(leak_factor), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    apb_read(8'h04, 32'h0, "t7_status");
    apb_read(8'h84, 32'd0, "t7_scount1");
    apb_read(8'h10, 32'h0, "t7_result");
    apb_read(8'h0C, 32'd8, "t7_steps_reg");
    apb_write(8'h00, 32'h1);
    wait_done(n);
    check("t7_latency", 32'(n), 27);
    apb_read(8'h10, 32'h0801, "t7_result2");
    apb_read(8'h84, 32'd8, "t7_scount1b");

    // Interrupt
    apb_write(8'h04, 32'h2);
    apb_write(8'h0C, 32'd2);
`ifdef SNN_CTRL_IRQ_EN
    apb_write(8'h00, 32'h2);
    apb_read(8'h00, 32'h2, "t8_ctrl_irq_en");
    check("t8_irq_idle", 32'(irq), 0);
    apb_write(8'h00, 32'h3);
    wait_done(n);
    check("t8_latency", 32'(n), 21);
    check("t8_irq_at_done", 32'(irq), 0);
    @(posedge clk); #1;
    check("t8_irq_rise", 32'(irq), 1);
    apb_write(8'h04, 32'h2);
    check("t8_irq_hold", 32'(irq), 1);
    @(posedge clk); #1;
    check("t8_irq_fall", 32'(irq), 0);
`else
    apb_write(8'h00, 32'h2);
    apb_read(8'h00, 32'h0, "t8_ctrl_no_irq_en");
    apb_write(8'h00, 32'h3);
    wait_done(n);
    check("t8_latency", 32'(n), 21);
    @(posedge clk); #1;
    check("t8_irq_tied", 32'(irq), 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_infer_ctrl.md
Name: snn_infer_ctrl

Overview:
- APB-programmed inference sequencer for the SNN network. Holds the pixel frame, leak factor and timestep count.
- Sequences one inference as: network clear, then N timesteps, then argmax over accumulated output spikes.
- Sits between the APB bus and the network datapath (pixel_input, leak_factor, digit_spikes). Exposes per-digit spike counts and the winning digit to software.

Parameters:
- INPUT_SIZE, 64, number of pixels; legal range 4..64, multiple of 4.
- OUTPUT_SIZE, 16, number of output neurons; legal range 2..16.
- PIXEL_WIDTH, 8, pixel width; fixed at 8, four pixels per APB word.
- CNT_W, 8, width of each per-digit spike counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  8  APB byte address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pixel_input  out  INPUT_SIZE*PIXEL_WIDTH  flattened pixel frame; pixel i at bits [8i+7:8i]
- leak_factor  out  8  leak factor to the network
- net_clear  out  1  one-cycle pulse that clears membrane state
- net_step  out  1  advance the network one timestep
- digit_spikes  in  OUTPUT_SIZE  spike vector; valid the cycle after each net_step
- irq  out  1  inference-done interrupt (see Optional Feature)

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. All registers clear to 0, FSM goes to IDLE, prdata=0, net_clear=0, net_step=0, irq=0. Exception: STEPS resets to 8.
- A reset mid-inference aborts immediately. Counters and RESULT clear.
- APB protocol:
  - pready is tied to 1 (zero wait states).
  - A write commits on psel&penable&pwrite.
  - prdata is driven combinationally when psel&!pwrite, and is 0 otherwise. Unmapped addresses read 0.
- Register map (word aligned; paddr[1:0] ignored):
  - 0x00 CTRL: [0] START, write-1 pulse, reads 0. [1] IRQ_EN.
  - 0x04 STATUS: [0] BUSY, read-only. [1] DONE, write-1-to-clear.
  - 0x08 LEAK [7:0].
  - 0x0C STEPS [7:0].
  - 0x10 RESULT: [3:0] winner, [15:8] winning count.
  - 0x40 + 4k PIXEL word k: byte j = pixel 4k+j.
  - 0x80 + 4d SCOUNT[d] [CNT_W-1:0], read-only.
- While BUSY:
  - Writes to LEAK, STEPS and PIXEL are ignored.
  - START is ignored.
  - Writes to CTRL.IRQ_EN and the DONE W1C still take effect.
- FSM:
  - IDLE: on START, clear all SCOUNT, clear DONE, latch steps_left=STEPS, go to CLEAR.
  - CLEAR: net_clear=1 for exactly 1 cycle. Go to RUN, or to DRAIN if STEPS==0.
  - RUN: net_step=1 every cycle. steps_left decrements each cycle; on the cycle it reaches 1, go to DRAIN. Gives exactly STEPS net_step pulses.
  - DRAIN: 1 cycle. Captures the spikes of the final step.
  - ARGMAX: OUTPUT_SIZE cycles, scanning d=0..OUTPUT_SIZE-1. Replace the best only on strict greater-than, so ties go to the lowest index.
  - DONE: write RESULT, set DONE, go to IDLE.
- Accumulation:
  - step_d is net_step delayed by 1 cycle.
  - When step_d=1, SCOUNT[d] increments for each set digit_spikes[d], saturating at 2^CNT_W-1.
  - digit_spikes is ignored when step_d=0.
- BUSY=1 in every state except IDLE.
- Latency from START write to DONE=1 is STEPS+OUTPUT_SIZE+3 cycles.
- RESULT holds its value until the next START's DONE state.
- A START written in the same cycle as a DONE W1C: the start wins and DONE ends at 0.
- pixel_input and leak_factor are driven directly from the registers and are stable throughout an inference.

Optional Feature:
- Macro: SNN_CTRL_IRQ_EN.
- With the macro: irq is a registered level equal to DONE & CTRL.IRQ_EN. It drops the cycle after DONE is cleared or IRQ_EN is cleared.
- Without the macro:
  - irq is tied to 0.
  - CTRL[1] reads 0 and is not stored.

Decomposition:
- Package snn_ctrl_pkg holds:
  - Address constants: ADDR_CTRL, ADDR_STATUS, ADDR_LEAK, ADDR_STEPS, ADDR_RESULT, ADDR_PIXEL_BASE, ADDR_SCOUNT_BASE.
  - FSM state enum ctrl_state_e: IDLE, CLEAR, RUN, DRAIN, ARGMAX, DONE.
  - The STEPS reset value.
- Sub-module snn_spike_accum holds:
  - The OUTPUT_SIZE saturating counters, with clear, enable and spike-vector inputs.
  - The sequential argmax scan.
  - It outputs the counts, winner and winning count.

Test Plan:
- Reset read-back: read all registers after reset -> STEPS=8, others 0, net_step/net_clear low, irq=0.
- Basic inference: PIXEL all 0x80, LEAK=0x10, STEPS=4; model returns spikes only on digit 3 each step.
  - Expect one net_clear pulse, then 4 net_step cycles.
  - Expect SCOUNT[3]=4, RESULT winner=3 with count 4, DONE after 23 cycles.
- Tie and saturation:
  - Digits 2 and 5 spike every step with STEPS=5 -> winner=2.
  - Digit 0 spiking with STEPS=255 and a repeat of 255 -> SCOUNT[0]=255 (saturates, no wrap).
- STEPS=0 -> no net_step pulses, all SCOUNT=0, winner=0, DONE after 19 cycles.
- Busy protection: START, then LEAK=0x55 and PIXEL word 0 writes plus a second START during RUN -> LEAK and pixels unchanged, only one inference runs.
- Reset mid-RUN: assert rst at step 2 -> all outputs 0 immediately, BUSY=0, SCOUNT=0. A new START then completes normally.
- With SNN_CTRL_IRQ_EN, IRQ_EN=1: irq rises the cycle after DONE is set and falls the cycle after DONE is written 1.
